// File: rtl/instr_params.sv
// Shared constants for the instruction fetch sequencer: FSM state encoding,
// instruction-pointer enable-select codes, next-pointer load codes and the
// DONE opcode.
package instr_params;

  typedef logic [1:0] state_t;

  // FSM state encoding
  localparam state_t StFetch = 2'd0;
  localparam state_t StWait  = 2'd1;
  localparam state_t StExec  = 2'd2;
  localparam state_t StHalt  = 2'd3;

  // instr_ptr_en_sel codes; 4-7 behave as ALWAYS
  localparam logic [2:0] INST_PTR_ALWAYS_EN = 3'd0;
  localparam logic [2:0] INST_PTR_QCLK_EN   = 3'd1;
  localparam logic [2:0] INST_PTR_SYNC_EN   = 3'd2;
  localparam logic [2:0] INST_PTR_FPROC_EN  = 3'd3;

  // instr_ptr_load_en codes
  localparam logic [1:0] INSTR_PTR_LOAD_EN_INC  = 2'b00;
  localparam logic [1:0] INSTR_PTR_LOAD_EN_JUMP = 2'b01;
  localparam logic [1:0] INSTR_PTR_LOAD_EN_COND = 2'b10;
  localparam logic [1:0] INSTR_PTR_LOAD_EN_RSVD = 2'b11;

  // Opcode[7:3] value that halts the core
  localparam logic [4:0] DONE_I = 5'b01100;

endpackage

// File: rtl/instr_ptr_next.sv
// Combinational next-address mux and enable (go) select for the fetch
// sequencer. Kept separate so it can be reused and unit-tested on its own.
module instr_ptr_next
  import instr_params::*;
#(
  parameter int unsigned AddrW = 16
) (
  input  logic [AddrW-1:0] instr_ptr_i,
  input  logic [AddrW-1:0] jump_addr_i,
  input  logic [1:0]       load_en_i,
  input  logic [2:0]       en_sel_i,
  input  logic             cond_i,
  input  logic             qclk_trig_i,
  input  logic             sync_in_i,
  input  logic             fproc_ready_i,
  output logic             go_o,
  output logic [AddrW-1:0] next_ptr_o
);

  logic [AddrW-1:0] ptr_inc;

  // Increment wraps modulo 2^AddrW by construction of the width
  assign ptr_inc = instr_ptr_i + AddrW'(1);

  // Enable source select
  always_comb begin
    go_o = 1'b1;
    unique case (en_sel_i)
      INST_PTR_QCLK_EN:  go_o = qclk_trig_i;
      INST_PTR_SYNC_EN:  go_o = sync_in_i;
      INST_PTR_FPROC_EN: go_o = fproc_ready_i;
      default:           go_o = 1'b1;
    endcase
  end

  // Next-pointer select; reserved code falls back to sequential flow
  always_comb begin
    next_ptr_o = ptr_inc;
    unique case (load_en_i)
      INSTR_PTR_LOAD_EN_JUMP: next_ptr_o = jump_addr_i;
      INSTR_PTR_LOAD_EN_COND: next_ptr_o = cond_i ? jump_addr_i : ptr_inc;
      default:                next_ptr_o = ptr_inc;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction pointer and fetch sequencer (FETCH -> WAIT -> EXEC, HALT on DONE).
// Optional feature: define INSTR_FETCH_STALL_CNT_EN to add the saturating
// stall_cycles counter of EXEC cycles spent waiting on the enable source.
module instr_fetch
  import instr_params::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 128
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_en,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instr_word,
  output logic [7:0]         opcode,
  input  logic [2:0]         instr_ptr_en_sel,
  input  logic [1:0]         instr_ptr_load_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic [31:0]        alu_result,
  input  logic               qclk_trig,
  input  logic               sync_in,
  input  logic               fproc_ready,
  output logic               exec_fire,
`ifdef INSTR_FETCH_STALL_CNT_EN
  output logic [31:0]        stall_cycles,
`endif
  output logic [ADDR_W-1:0]  instr_ptr,
  output logic               done
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   instr_ptr_q, instr_ptr_d;
  logic [INSTR_W-1:0]  instr_word_q, instr_word_d;
  logic                go;
  logic                fire;
  logic [ADDR_W-1:0]   next_ptr;
  logic                unused_alu;

  // Only the condition bit of the ALU result steers the pointer
  assign unused_alu = ^alu_result[31:1];

  instr_ptr_next #(
    .AddrW (ADDR_W)
  ) u_instr_ptr_next (
    .instr_ptr_i   (instr_ptr_q),
    .jump_addr_i   (jump_addr),
    .load_en_i     (instr_ptr_load_en),
    .en_sel_i      (instr_ptr_en_sel),
    .cond_i        (alu_result[0]),
    .qclk_trig_i   (qclk_trig),
    .sync_in_i     (sync_in),
    .fproc_ready_i (fproc_ready),
    .go_o          (go),
    .next_ptr_o    (next_ptr)
  );

  assign opcode = instr_word_q[INSTR_W-1 -: 8];

  // FSM next state, pointer update and instruction capture
  always_comb begin
    state_d      = state_q;
    instr_ptr_d  = instr_ptr_q;
    instr_word_d = instr_word_q;
    fire         = 1'b0;
    unique case (state_q)
      StFetch: state_d = StWait;
      StWait: begin
        instr_word_d = mem_data;
        state_d      = StExec;
      end
      StExec: begin
        if (go) begin
          if (opcode[7:3] == DONE_I) begin
            state_d = StHalt;
          end else begin
            fire        = 1'b1;
            instr_ptr_d = next_ptr;
            state_d     = StFetch;
          end
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFetch;
      instr_ptr_q  <= '0;
      instr_word_q <= '0;
    end else begin
      state_q      <= state_d;
      instr_ptr_q  <= instr_ptr_d;
      instr_word_q <= instr_word_d;
    end
  end

`ifdef INSTR_FETCH_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count EXEC cycles held by a low enable, saturating at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((state_q == StExec) && !go && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

  // Reset masks the read enable and the retire pulse in the reset cycle
  assign mem_addr   = instr_ptr_q;
  assign mem_en     = (state_q == StFetch) && !reset;
  assign exec_fire  = fire && !reset;
  assign instr_ptr  = instr_ptr_q;
  assign instr_word = instr_word_q;
  assign done       = (state_q == StHalt);

endmodule
